branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer side of the EX-stage compare interface.
- Drives the comparator's signedness select, takes back its equal/less flags, and resolves conditional branches, JAL and JALR against the fetch prediction.
- On a mispredict, issues a handshaked redirect to fetch, then a timed flush of the younger pipeline stages.
- Holds a small 2-bit-counter branch history table (BHT) that fetch reads and this block trains.

Parameters:
- XLEN, 32, data and PC width.
- BHT_ENTRIES, 64, number of BHT counters; must be a power of two, minimum 2.
- FLUSH_CYCLES, 2, number of cycles flush_o is held after the redirect is accepted; 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- res_valid_i  in  1  EX presents a control-flow instruction.
- res_ready_o  out  1  block can accept a resolve this cycle.
- is_branch_i  in  1  conditional branch.
- is_jal_i  in  1  JAL.
- is_jalr_i  in  1  JALR.
- funct3_i  in  3  branch funct3.
- pc_i  in  XLEN  instruction PC.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_i  in  XLEN  rs1 data, used for the JALR target.
- pred_taken_i  in  1  fetch's taken prediction.
- pred_target_i  in  XLEN  fetch's predicted target.
- uns_o  out  1  comparator unsigned select; equals funct3_i[1].
- equal_i  in  1  comparator equal flag.
- less_i  in  1  comparator less flag.
- redirect_valid_o  out  1  redirect request to fetch.
- redirect_ready_i  in  1  fetch accepts the redirect.
- redirect_pc_o  out  XLEN  corrected PC.
- flush_o  out  1  kill IF/ID/EX contents.
- lookup_pc_i  in  XLEN  fetch PC for the BHT read.
- lookup_taken_o  out  1  BHT prediction.

Behaviour:
- Accept: an instruction is accepted when res_valid_i && res_ready_o. res_ready_o = (state==IDLE).
- Flags: uns_o is combinational and valid whenever res_valid_i is high. equal_i and less_i are sampled in the same cycle as the accept.
- Taken, by funct3:
  - 000 BEQ: equal_i.
  - 001 BNE: !equal_i.
  - 100 BLT / 110 BLTU: less_i.
  - 101 BGE / 111 BGEU: !less_i.
  - 010, 011: not taken, no BHT update, never a mispredict.
  - JAL and JALR: always taken.
- Targets:
  - Branch and JAL: pc_i+imm_i.
  - JALR: (rs1_i+imm_i) with bit0 cleared.
  - All adds are mod 2^XLEN.
  - Fall-through: pc_i+4.
- Mispredict = (taken != pred_taken_i) || (taken && target != pred_target_i).
- Corrected PC: taken ? target : pc_i+4. It is registered into redirect_pc_o on the accept.
- FSM states IDLE, REDIRECT, FLUSH.
  - IDLE → REDIRECT on an accepted mispredict. redirect_valid_o=1 and flush_o=1 from the next cycle.
  - REDIRECT: redirect_valid_o and redirect_pc_o stay stable until redirect_ready_i. On the handshake cycle go to FLUSH and load the counter with FLUSH_CYCLES-1.
  - FLUSH: redirect_valid_o=0, flush_o=1. The counter decrements each cycle; go to IDLE when it is 0.
  - Correct prediction: stay in IDLE, no outputs change.
- Latency: redirect appears 1 cycle after the accept. Total block time from accept to IDLE = 1 + fetch wait + FLUSH_CYCLES.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2].
  - lookup_taken_o = counter[idx(lookup_pc_i)][1], combinational.
  - Each accepted conditional branch with legal funct3 updates its counter at the clock edge: taken increments, saturating at 3; not taken decrements, saturating at 0.
  - JAL and JALR do not update.
  - A lookup and an update to the same index in the same cycle: the lookup returns the pre-update value.
- Simultaneous flags/handshakes: res_valid_i while not IDLE is ignored (ready=0). redirect_ready_i outside REDIRECT is ignored.
- Reset, asynchronous:
  - state=IDLE, counter=0.
  - redirect_valid_o=0, flush_o=0, redirect_pc_o=0.
  - All BHT counters=2'b01 (weakly not taken).
  - Reset mid-REDIRECT or mid-FLUSH aborts immediately; no redirect completes.

Optional Feature:
- BRANCH_STATS_EN: adds output ports stat_branches_o and stat_mispred_o (32-bit each).
  - stat_branches_o counts every accept.
  - stat_mispred_o counts every accepted mispredict.
  - Both wrap at 2^32 and reset to 0.
- Without the macro, these ports and counters do not exist.

Test Plan:
- BEQ, pc=0x100, imm=0x20, equal_i=1, pred_taken=0 → next cycle redirect_valid_o=1, redirect_pc_o=0x120. With ready=1 that cycle, flush_o is high 1+2 cycles, then res_ready_o=1.
- BGEU, funct3=111, less_i=0, pred_taken=1, pred_target=pc+imm → uns_o=1, no redirect, and BHT counter 01→10.
- JALR, rs1=0x2001, imm=0x4, pred_target=0x2000 → redirect_pc_o=0x2004, and redirect_valid_o holds with ready=0 for 5 cycles with the PC stable.
- Four taken BLT at the same PC, then lookup_pc_i=that PC → lookup_taken_o=1 and the counter saturates at 3. Four not-taken → 0, and lookup_taken_o=0.
- Assert rst_i during REDIRECT → redirect_valid_o and flush_o drop asynchronously, and all lookups return 0.
- funct3=010 with res_valid_i=1 → not taken, no BHT change, no mispredict, even if pred_taken=1 (stats, if enabled: branches+1, mispred+0).

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : EX-stage branch/jump resolution. It drives the comparator sign
//            select and resolves conditional branches, JAL and JALR against
//            the fetch prediction. A mispredict raises a handshaked redirect
//            to fetch, followed by a timed flush of the younger stages. The
//            block also owns a 2-bit-counter branch history table.
// Options  : define BRANCH_STATS_EN to add the stat_branches_o and
//            stat_mispred_o counter ports.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            uns_o,
  input  logic            equal_i,
  input  logic            less_i,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      flush_cnt;
  logic [3:0]      flush_cnt_next;

  logic            accept;
  logic            legal_cond;
  logic            cond_taken;
  logic            taken;
  logic            kind_valid;
  logic            mispredict;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_through;
  logic [XLEN-1:0] corrected_pc;

  logic [1:0]      bht [BHT_ENTRIES];
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] look_idx;
  logic [1:0]      upd_cur;
  logic [1:0]      upd_next;
  logic            bht_we;

  // Bits that do not participate in indexing or in the aligned JALR target.
  logic            unused_bits;
  assign unused_bits = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0], jalr_sum[0]};

  // Resolve is only taken while idle, so busy-state requests simply stall.
  assign accept = res_valid_i && (state == IDLE);
  assign uns_o  = funct3_i[1];

  // funct3 010/011 are not branch encodings; they never train or mispredict.
  assign legal_cond = is_branch_i && (funct3_i[2] || !funct3_i[1]);

  // Condition evaluation from the comparator flags.
  always_comb begin
    cond_taken = 1'b0;
    case (funct3_i)
      3'b000:         cond_taken = equal_i;
      3'b001:         cond_taken = !equal_i;
      3'b100, 3'b110: cond_taken = less_i;
      3'b101, 3'b111: cond_taken = !less_i;
      default:        cond_taken = 1'b0;
    endcase
  end

  assign branch_target = pc_i + imm_i;
  assign jalr_sum      = rs1_i + imm_i;
  assign target        = is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : branch_target;
  assign fall_through  = pc_i + XLEN'(4);
  assign taken         = is_jal_i || is_jalr_i || (legal_cond && cond_taken);
  assign kind_valid    = legal_cond || is_jal_i || is_jalr_i;
  assign mispredict    = kind_valid &&
                         ((taken != pred_taken_i) || (taken && (target != pred_target_i)));
  assign corrected_pc  = taken ? target : fall_through;

  // State and flush counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next-state logic; the handshake and flush outputs decode straight from the state.
  always_comb begin
    state_next       = state;
    flush_cnt_next   = flush_cnt;
    res_ready_o      = 1'b0;
    redirect_valid_o = 1'b0;
    flush_o          = 1'b0;
    case (state)
      IDLE: begin
        res_ready_o = 1'b1;
        if (accept && mispredict) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        flush_o          = 1'b1;
        if (redirect_ready_i) begin
          state_next     = FLUSH;
          flush_cnt_next = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (flush_cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          flush_cnt_next = flush_cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the corrected PC only when a redirect is about to start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_pc_o <= '0;
    end else if (accept && mispredict) begin
      redirect_pc_o <= corrected_pc;
    end
  end

  assign upd_idx        = pc_i[IDX_W+1:2];
  assign look_idx       = lookup_pc_i[IDX_W+1:2];
  assign lookup_taken_o = bht[look_idx][1];
  assign bht_we         = accept && legal_cond;
  assign upd_cur        = bht[upd_idx];

  // Saturating 2-bit counter step.
  always_comb begin
    upd_next = upd_cur;
    if (cond_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
    end
  end

  // BHT storage; reads are combinational so a same-cycle lookup sees the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < BHT_ENTRIES; e++) begin
        bht[e] <= 2'b01;
      end
    end else if (bht_we) begin
      bht[upd_idx] <= upd_next;
    end
  end

`ifdef BRANCH_STATS_EN
  // Resolve and mispredict event counters, wrapping naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_branches_o <= 32'd0;
      stat_mispred_o  <= 32'd0;
    end else if (accept) begin
      stat_branches_o <= stat_branches_o + 32'd1;
      if (mispredict) begin
        stat_mispred_o <= stat_mispred_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Self-checking bench for branch_resolve_unit. Directed scenarios
//            followed by randomized resolves against a behavioural model.
// Options  : BRANCH_STATS_EN also checks the statistic counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int ENT  = 64;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            res_valid;
  logic            res_ready;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            uns;
  logic            equal_f;
  logic            less_f;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [XLEN-1:0] lookup_pc;
  logic            lookup_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispred;
`endif

  branch_resolve_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(ENT), .FLUSH_CYCLES(FC)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .is_branch_i(is_branch), .is_jal_i(is_jal), .is_jalr_i(is_jalr),
    .funct3_i(funct3), .pc_i(pc), .imm_i(imm), .rs1_i(rs1),
    .pred_taken_i(pred_taken), .pred_target_i(pred_target),
    .uns_o(uns), .equal_i(equal_f), .less_i(less_f),
    .redirect_valid_o(redirect_valid), .redirect_ready_i(redirect_ready),
    .redirect_pc_o(redirect_pc), .flush_o(flush),
    .lookup_pc_i(lookup_pc), .lookup_taken_o(lookup_taken)
`ifdef BRANCH_STATS_EN
    , .stat_branches_o(stat_branches), .stat_mispred_o(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          bht_m [ENT];
  logic [31:0] rpc_m;
  int unsigned br_m;
  int unsigned mp_m;
  logic [31:0] obs_rpc;
  int          flush_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % ENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) bht_m[i] = 1;
    rpc_m = 32'd0;
    br_m  = 0;
    mp_m  = 0;
  endtask

  // Architectural meaning of a resolve: kind 0 = branch, 1 = JAL, 2 = JALR.
  task automatic ref_resolve(input int kind, input logic [2:0] f3,
                             input logic [31:0] a_pc, a_imm, a_rs1,
                             input logic eq, lt,
                             output logic tk, output logic [31:0] tgt, output logic upd);
    upd = 1'b0;
    tk  = 1'b0;
    tgt = (kind == 2) ? ((a_rs1 + a_imm) & 32'hFFFF_FFFE) : (a_pc + a_imm);
    if (kind != 0) begin
      tk = 1'b1;
    end else begin
      case (int'(f3))
        0:    tk = eq;
        1:    tk = !eq;
        4, 6: tk = lt;
        5, 7: tk = !lt;
        default: tk = 1'b0;
      endcase
      upd = (f3 != 3'd2) && (f3 != 3'd3);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_stbr"}, stat_branches, br_m);
    check({tag, "_stmp"}, stat_mispred, mp_m);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One complete resolve, from the accept through the end of any redirect/flush.
  task automatic resolve(input int kind, input logic [2:0] f3,
                         input logic [31:0] a_pc, a_imm, a_rs1,
                         input logic eq, lt, pt, input logic [31:0] ptgt,
                         input logic [31:0] lpc, input int wait_cycles);
    logic        tk, upd, mis;
    logic [31:0] tgt;
    int          li, ui;
    ref_resolve(kind, f3, a_pc, a_imm, a_rs1, eq, lt, tk, tgt, upd);
    mis = ((kind != 0) || upd) && ((tk != pt) || (tk && (tgt != ptgt)));
    flush_obs = 0;

    @(negedge clk);
    res_valid = 1'b1;
    is_branch = (kind == 0); is_jal = (kind == 1); is_jalr = (kind == 2);
    funct3 = f3; pc = a_pc; imm = a_imm; rs1 = a_rs1;
    equal_f = eq; less_f = lt; pred_taken = pt; pred_target = ptgt;
    lookup_pc = lpc;
    redirect_ready = 1'($urandom_range(0, 1));
    #1;
    li = idx_of(lpc);
    check("acc_ready", 32'(res_ready), 32'd1);
    check("uns", 32'(uns), 32'(f3[1]));
    check("lookup_pre", 32'(lookup_taken), 32'(bht_m[li] >= 2));

    @(posedge clk);
    br_m++;
    if (upd) begin
      ui = idx_of(a_pc);
      if (tk) bht_m[ui] = (bht_m[ui] == 3) ? 3 : bht_m[ui] + 1;
      else    bht_m[ui] = (bht_m[ui] == 0) ? 0 : bht_m[ui] - 1;
    end
    if (mis) begin
      mp_m++;
      rpc_m = tk ? tgt : a_pc + 32'd4;
    end

    @(negedge clk);
    res_valid = 1'b0;
    redirect_ready = 1'b0;
    #1;
    if (mis) begin
      check("rd_valid", 32'(redirect_valid), 32'd1);
      check("rd_flush", 32'(flush), 32'd1);
      check("rd_pc", redirect_pc, rpc_m);
      obs_rpc = redirect_pc;
      for (int w = 0; w < wait_cycles; w++) begin
        res_valid = 1'b1; is_branch = 1'b1; is_jal = 1'b0; is_jalr = 1'b0;
        funct3 = 3'($urandom_range(0, 7)); pc = $urandom; imm = $urandom;
        equal_f = 1'($urandom_range(0, 1)); less_f = 1'($urandom_range(0, 1));
        pred_taken = 1'($urandom_range(0, 1));
        #1;
        check("wait_valid", 32'(redirect_valid), 32'd1);
        check("wait_pc", redirect_pc, rpc_m);
        check("wait_ready", 32'(res_ready), 32'd0);
        if (flush) flush_obs++;
        @(negedge clk);
      end
      res_valid = 1'b0;
      redirect_ready = 1'b1;
      #1;
      check("hs_valid", 32'(redirect_valid), 32'd1);
      if (flush) flush_obs++;
      @(negedge clk);
      for (int k = 0; k < FC; k++) begin
        redirect_ready = 1'($urandom_range(0, 1));
        #1;
        check("fl_flush", 32'(flush), 32'd1);
        check("fl_valid", 32'(redirect_valid), 32'd0);
        check("fl_ready", 32'(res_ready), 32'd0);
        if (flush) flush_obs++;
        @(negedge clk);
      end
      redirect_ready = 1'b0;
      #1;
      check("end_flush", 32'(flush), 32'd0);
      check("end_ready", 32'(res_ready), 32'd1);
    end else begin
      check("ok_valid", 32'(redirect_valid), 32'd0);
      check("ok_flush", 32'(flush), 32'd0);
      check("ok_ready", 32'(res_ready), 32'd1);
      check("ok_pc", redirect_pc, rpc_m);
    end
    check_stats("res");
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic exp);
    @(negedge clk);
    lookup_pc = a;
    #1;
    check(tag, 32'(lookup_taken), 32'(exp));
  endtask

  initial begin
    logic        tk, upd;
    logic [31:0] tgt, rpc, rimm, rrs1, rpt;
    logic [2:0]  rf3;
    logic        req, rlt, rptk;
    int          kind;
    logic [31:0] hot [4];
    hot[0] = 32'h1000; hot[1] = 32'h1004; hot[2] = 32'h2040; hot[3] = 32'h1100;

    rst = 1'b1;
    res_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'd0; pc = '0; imm = '0; rs1 = '0; pred_taken = 1'b0; pred_target = '0;
    equal_f = 1'b0; less_f = 1'b0; redirect_ready = 1'b0; lookup_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(redirect_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_ready", 32'(res_ready), 32'd1);
    check("rst_lookup", 32'(lookup_taken), 32'd0);
    check_stats("rst");
    rst = 1'b0;

    // BEQ taken but predicted not taken; immediate acceptance by fetch.
    resolve(0, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100, 0);
    check("beq_pc", obs_rpc, 32'h120);
    check("beq_flush_len", 32'(flush_obs), 32'(1 + FC));

    // BGEU correctly predicted taken; trains 01 -> 10.
    resolve(0, 3'b111, 32'h204, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 32'h244, 32'h204, 0);
    peek("bgeu_bht", 32'h204, 1'b1);

    // JALR with target bit0 cleared; fetch stalls five cycles.
    resolve(2, 3'b000, 32'h3000, 32'h4, 32'h2001, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h0, 5);
    check("jalr_pc", obs_rpc, 32'h2004);

    // Counter saturation at both ends.
    for (int i = 0; i < 4; i++)
      resolve(0, 3'b100, 32'h308, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h318, 32'h308, 0);
    peek("blt_sat3", 32'h308, 1'b1);
    resolve(0, 3'b100, 32'h308, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h308, 0);
    peek("blt_3to2", 32'h308, 1'b1);
    for (int i = 0; i < 3; i++)
      resolve(0, 3'b100, 32'h308, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h308, 0);
    peek("blt_sat0", 32'h308, 1'b0);
    resolve(0, 3'b100, 32'h308, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h318, 32'h308, 0);
    peek("blt_0to1", 32'h308, 1'b0);
    resolve(0, 3'b100, 32'h308, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h318, 32'h308, 0);
    peek("blt_1to2", 32'h308, 1'b1);

    // Illegal funct3: no mispredict despite a taken prediction, no training.
    resolve(0, 3'b010, 32'h30C, 32'h8, 32'h0, 1'b1, 1'b1, 1'b1, 32'h314, 32'h30C, 0);
    resolve(0, 3'b000, 32'h30C, 32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 32'h314, 32'h30C, 0);
    peek("f3_010_nochg", 32'h30C, 1'b1);

    // Reset in the middle of a pending redirect.
    @(negedge clk);
    res_valid = 1'b1; is_branch = 1'b0; is_jal = 1'b1; is_jalr = 1'b0;
    funct3 = 3'd0; pc = 32'h500; imm = 32'h40; pred_taken = 1'b0;
    @(negedge clk);
    res_valid = 1'b0; is_jal = 1'b0;
    #1;
    check("rst_pre_valid", 32'(redirect_valid), 32'd1);
    check("rst_pre_lookup", 32'(lookup_taken), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(redirect_valid), 32'd0);
    check("arst_flush", 32'(flush), 32'd0);
    check("arst_pc", redirect_pc, 32'd0);
    check("arst_lookup", 32'(lookup_taken), 32'd0);
    model_reset();
    check_stats("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_valid", 32'(redirect_valid), 32'd0);
    check("post_rst_ready", 32'(res_ready), 32'd1);

    // Randomized resolves.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 4);
      kind = (kind <= 2) ? 0 : kind - 2;
      if (kind == 0 && $urandom_range(0, 3) == 0) kind = 2;
      rf3  = 3'($urandom_range(0, 7));
      rpc  = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 3)] : ($urandom & 32'hFFFF_FFFC);
      rimm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255) * 4) : $urandom;
      rrs1 = $urandom;
      req  = 1'($urandom_range(0, 1));
      rlt  = 1'($urandom_range(0, 1));
      ref_resolve(kind, rf3, rpc, rimm, rrs1, req, rlt, tk, tgt, upd);
      if ($urandom_range(0, 1) == 1) begin
        rptk = tk;
        rpt  = tk ? tgt : $urandom;
      end else begin
        rptk = 1'($urandom_range(0, 1));
        rpt  = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
      end
      resolve(kind, rf3, rpc, rimm, rrs1, req, rlt, rptk, rpt,
              ($urandom_range(0, 1) == 1) ? rpc : hot[$urandom_range(0, 3)],
              $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
